// File: rtl/fifo_op_pipeline.sv
// Operand-pair pipeline: input FIFO -> one registered bitwise-op stage -> FWFT output FIFO.
// Each item carries its own op select, so mixed operations may be in flight at once.
module fifo_op_pipeline #(
    parameter int WIDTH     = 1,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_a,
    input  logic [WIDTH-1:0]             in_b,
    input  logic [1:0]                   in_op,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(IN_DEPTH):0]    in_level,
    output logic [$clog2(OUT_DEPTH):0]   out_level
);

    localparam int IAW = $clog2(IN_DEPTH);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int IW  = 2 + 2 * WIDTH;
    localparam logic [IAW:0] IN_FULL  = (IAW + 1)'(IN_DEPTH);
    localparam logic [OAW:0] OUT_FULL = (OAW + 1)'(OUT_DEPTH);

    logic [IW-1:0]    in_mem [IN_DEPTH];
    logic [IAW-1:0]   in_wr_ptr, in_rd_ptr;
    logic [WIDTH-1:0] out_mem [OUT_DEPTH];
    logic [OAW-1:0]   out_wr_ptr, out_rd_ptr;

    logic             stage_valid;
    logic [WIDTH-1:0] stage_data;
    logic [WIDTH-1:0] result;
    logic [IW-1:0]    in_head;
    logic             in_push, in_pop, stage_wr, out_pop;

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // a flush on that edge discards it. ready never depends on valid of the same port.
    assign in_ready  = rst & (in_level != IN_FULL);
    assign out_valid = (out_level != '0);
    assign out_data  = out_mem[out_rd_ptr];

    assign stage_wr = stage_valid & (out_level != OUT_FULL) & ~flush;
    assign in_push  = in_valid & in_ready & ~flush;
    assign in_pop   = (in_level != '0) & (~stage_valid | stage_wr) & ~flush;
    assign out_pop  = out_valid & out_ready & ~flush;

    assign in_head = in_mem[in_rd_ptr];

    always_comb begin
        result = '0;
        case (in_head[IW-1:IW-2])
            2'b00:   result = in_head[2*WIDTH-1:WIDTH] ^ in_head[WIDTH-1:0];
            2'b01:   result = in_head[2*WIDTH-1:WIDTH] & in_head[WIDTH-1:0];
            2'b10:   result = in_head[2*WIDTH-1:WIDTH] | in_head[WIDTH-1:0];
            default: result = ~(in_head[2*WIDTH-1:WIDTH] ^ in_head[WIDTH-1:0]);
        endcase
    end

    // Storage arrays carry no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wr_ptr] <= {in_op, in_a, in_b};
        if (stage_wr) out_mem[out_wr_ptr] <= stage_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_level  <= '0;
        end else if (flush) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_level  <= '0;
        end else begin
            if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
            if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
            in_level <= in_level + (IAW + 1)'(in_push) - (IAW + 1)'(in_pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (flush) begin
            stage_valid <= 1'b0;
        end else if (in_pop) begin
            stage_valid <= 1'b1;
            stage_data  <= result;
        end else if (stage_wr) begin
            stage_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_level  <= '0;
        end else if (flush) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_level  <= '0;
        end else begin
            if (stage_wr) out_wr_ptr <= out_wr_ptr + 1'b1;
            if (out_pop)  out_rd_ptr <= out_rd_ptr + 1'b1;
            out_level <= out_level + (OAW + 1)'(stage_wr) - (OAW + 1)'(out_pop);
        end
    end

endmodule

// File: tb/tb_fifo_op_pipeline.sv
// Scoreboard bench for fifo_op_pipeline (WIDTH=8, both depths 4): driver tasks queue
// expected results on accept, a negedge monitor pops and compares on every output transfer.
module tb_fifo_op_pipeline;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic [2:0]   in_level;
    logic [2:0]   out_level;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    fifo_op_pipeline #(.WIDTH(W), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_level(in_level), .out_level(out_level)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, b, input logic [1:0] op);
        case (op)
            2'b00:   return a ^ b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~(a ^ b);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // driver: called at posedge+1, returns at posedge+1 after the accepting edge
    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [W-1:0] exp);
        bit done = 1'b0;
        int waited = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        while (!done) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (done) exp_q.push_back(exp);
            else if (++waited > 300) begin
                timeout("push_accept");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic push_rand();
        logic [W-1:0] a = W'($urandom);
        logic [W-1:0] b = W'($urandom);
        logic [1:0] op = 2'($urandom_range(0, 3));
        push(a, b, op, model(a, b, op));
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 || out_valid) begin
            @(posedge clk);
            #1;
            if (++k > 600) begin
                timeout("drain");
                exp_q.delete();
                break;
            end
        end
    endtask

    // single item into an empty pipeline: out_valid must rise right after edge t+2
    task automatic latency_check(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] op, input logic [W-1:0] exp);
        out_ready = 1'b1;
        push(a, b, op, exp);
        @(negedge clk);
        check("lat_after_t", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_after_t1", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("lat_after_t2", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            check("in_level_bound", 32'(in_level <= 3'd4), 32'd1);
            check("out_level_bound", 32'(out_level <= 3'd4), 32'd1);
            if (out_valid && out_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %0h with empty queue at %0t", out_data, $time);
                end else begin
                    check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // random back-pressure on the output side
    always begin
        @(posedge clk);
        #1;
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        // reset state
        #23;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_level", 32'(in_level), 32'd0);
        check("rst_out_level", 32'(out_level), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // directed mixed ops, back to back
        out_ready = 1'b1;
        latency_check(8'hA5, 8'h0F, 2'b00, 8'hAA);
        push(8'h01, 8'h00, 2'b00, 8'h01);
        push(8'h01, 8'h01, 2'b01, 8'h01);
        push(8'h00, 8'h00, 2'b10, 8'h00);
        push(8'h01, 8'h01, 2'b11, 8'hFF);
        push(8'hA5, 8'h0F, 2'b01, 8'h05);
        push(8'hA5, 8'h0F, 2'b10, 8'hAF);
        push(8'hA5, 8'h0F, 2'b11, 8'h55);
        wait_drain();

        // capacity: 9 items with output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push(W'(i), 8'hFF, 2'b00, W'(8'hFF ^ i));
        in_valid = 1'b1;
        in_a = 8'd9;
        in_b = 8'hFF;
        in_op = 2'b00;
        @(negedge clk);
        check("cap_in_ready", 32'(in_ready), 32'd0);
        check("cap_in_level", 32'(in_level), 32'd4);
        check("cap_out_level", 32'(out_level), 32'd4);
        @(negedge clk);
        check("cap_hold_in_level", 32'(in_level), 32'd4);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        push(8'd9, 8'hFF, 2'b00, 8'hF6);
        wait_drain();

        // full output with continuous traffic
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) push_rand();
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) push_rand();
        wait_drain();

        // random valid/ready toggling
        rand_mode = 1'b1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge clk);
                #1;
            end
            push_rand();
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        wait_drain();

        // flush with every buffer occupied
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push_rand();
        @(negedge clk);
        check("pre_flush_in_level", 32'(in_level), 32'd3);
        check("pre_flush_out_level", 32'(out_level), 32'd4);
        @(posedge clk);
        #1;
        flush = 1'b1;
        in_valid = 1'b1;
        in_a = 8'h33;
        in_b = 8'h44;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_level", 32'(in_level), 32'd0);
        check("flush_out_level", 32'(out_level), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        latency_check(8'hC3, 8'h3C, 2'b10, 8'hFF);
        wait_drain();

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_rand();
        #2;
        rst = 1'b0;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready", 32'(in_ready), 32'd0);
        check("async_in_level", 32'(in_level), 32'd0);
        check("async_out_level", 32'(out_level), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        latency_check(8'hF0, 8'h3C, 2'b11, 8'h33);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
